// File: rtl/axi_pkg.sv
// axi_pkg: shared response codes, slave index field position and route states for the interconnect.
package axi_pkg;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam int IDX_LSB = 16;
  typedef enum logic [1:0] {IDLE, DATA, RESP} route_state_e;
endpackage

// File: rtl/axi_wr_decode.sv
// axi_wr_decode: AWADDR slave index field to one-hot select plus unmapped flag.
module axi_wr_decode
  import axi_pkg::*;
#(
  parameter int SlaveCount = 6,
  parameter int AddrWidth = 32
) (
  input  logic [AddrWidth-1:0]  addr,
  output logic [SlaveCount-1:0] dec,
  output logic                  unmapped
);
  localparam int IdxW = AddrWidth - IDX_LSB;
  logic [IdxW-1:0] idx;
  logic            unused_lo;
  assign idx = addr[AddrWidth-1:IDX_LSB];
  assign unused_lo = ^addr[IDX_LSB-1:0];
  always_comb begin
    dec = '0;
    for (int i = 0; i < SlaveCount; i++) dec[i] = idx == IdxW'(i);
  end
  assign unmapped = ~|dec;
endmodule

// File: rtl/axi_wr_route.sv
// axi_wr_route: routes one master write channel to a one-hot slave, holding the route until B completes.
// Unmapped addresses go to an internal default slave that answers DECERR.
module axi_wr_route
  import axi_pkg::*;
#(
  parameter int SlaveCount = 6,
  parameter int AddrWidth = 32
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  input  logic [AddrWidth-1:0]    AWADDR_M,
  input  logic                    AWVALID_M,
  output logic                    AWREADY_M,
  output logic [SlaveCount-1:0]   AWVALID_S,
  input  logic [SlaveCount-1:0]   AWREADY_S,
  input  logic                    WVALID_M,
  input  logic                    WLAST_M,
  output logic                    WREADY_M,
  output logic [SlaveCount-1:0]   WVALID_S,
  input  logic [SlaveCount-1:0]   WREADY_S,
  input  logic [SlaveCount-1:0]   BVALID_S,
  input  logic [2*SlaveCount-1:0] BRESP_S,
  output logic                    BVALID_M,
  output logic [1:0]              BRESP_M,
  input  logic                    BREADY_M,
  output logic [SlaveCount-1:0]   BREADY_S,
  output logic                    BUSY
);
  route_state_e          state_q, state_d;
  logic [SlaveCount-1:0] sel_q, sel_d, dec;
  logic                  derr_q, derr_d, unmapped;
  logic [1:0]            bresp_sel;
  axi_wr_decode #(.SlaveCount(SlaveCount), .AddrWidth(AddrWidth)) u_dec (
    .addr(AWADDR_M),
    .dec(dec),
    .unmapped(unmapped)
  );
  always_comb begin
    bresp_sel = RESP_OKAY;
    for (int i = 0; i < SlaveCount; i++) bresp_sel |= sel_q[i] ? BRESP_S[2*i+:2] : 2'b00;
  end
  // Outputs stay 0 while ARESETn is low, even the purely combinational ones.
  always_comb begin
    state_d = state_q;
    sel_d = sel_q;
    derr_d = derr_q;
    AWREADY_M = 1'b0;
    AWVALID_S = '0;
    WREADY_M = 1'b0;
    WVALID_S = '0;
    BVALID_M = 1'b0;
    BRESP_M = RESP_OKAY;
    BREADY_S = '0;
    if (ARESETn) begin
      case (state_q)
        IDLE: begin
          AWVALID_S = dec & {SlaveCount{AWVALID_M}};
          AWREADY_M = unmapped | |(dec & AWREADY_S);
          if (AWVALID_M && AWREADY_M) begin
            sel_d = dec;
            derr_d = unmapped;
            state_d = DATA;
          end
        end
        DATA: begin
          WVALID_S = sel_q & {SlaveCount{WVALID_M}};
          WREADY_M = derr_q | |(sel_q & WREADY_S);
          state_d = WVALID_M && WREADY_M && WLAST_M ? RESP : DATA;
        end
        RESP: begin
          BVALID_M = derr_q | |(sel_q & BVALID_S);
          BRESP_M = derr_q ? RESP_DECERR : bresp_sel;
          BREADY_S = derr_q ? '0 : sel_q & {SlaveCount{BREADY_M}};
          if (BVALID_M && BREADY_M) begin
            state_d = IDLE;
            sel_d = '0;
            derr_d = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q <= IDLE;
      sel_q <= '0;
      derr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q <= sel_d;
      derr_q <= derr_d;
    end
  end
  assign BUSY = ARESETn && state_q != IDLE;
endmodule

// File: tb/tb_axi_wr_route.sv
// tb_axi_wr_route: table-driven transactions with a B-response scoreboard plus hand-written corner sequences.
module tb_axi_wr_route;
  localparam int SC = 6;
  localparam int AW = 32;
  logic          ACLK = 1'b0;
  logic          ARESETn = 1'b0;
  logic [AW-1:0] AWADDR_M = '0;
  logic          AWVALID_M = 1'b0, AWREADY_M;
  logic [SC-1:0] AWVALID_S, AWREADY_S = '0;
  logic          WVALID_M = 1'b0, WLAST_M = 1'b0, WREADY_M;
  logic [SC-1:0] WVALID_S, WREADY_S = '0;
  logic [SC-1:0] BVALID_S = '0;
  logic [2*SC-1:0] BRESP_S = '0;
  logic          BVALID_M, BREADY_M = 1'b0, BUSY;
  logic [1:0]    BRESP_M;
  logic [SC-1:0] BREADY_S;
  always #5 ACLK = ~ACLK;
  axi_wr_route #(.SlaveCount(SC), .AddrWidth(AW)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWADDR_M(AWADDR_M), .AWVALID_M(AWVALID_M), .AWREADY_M(AWREADY_M),
    .AWVALID_S(AWVALID_S), .AWREADY_S(AWREADY_S),
    .WVALID_M(WVALID_M), .WLAST_M(WLAST_M), .WREADY_M(WREADY_M),
    .WVALID_S(WVALID_S), .WREADY_S(WREADY_S),
    .BVALID_S(BVALID_S), .BRESP_S(BRESP_S),
    .BVALID_M(BVALID_M), .BRESP_M(BRESP_M), .BREADY_M(BREADY_M),
    .BREADY_S(BREADY_S), .BUSY(BUSY)
  );
  int n_chk = 0;
  int n_pass = 0;
  typedef struct {
    logic [31:0] addr;
    int          beats;
    logic [1:0]  bresp;
    logic [5:0]  sel;
    logic [1:0]  exp_resp;
  } vec_t;
  typedef struct {
    logic [1:0] resp;
    logic [5:0] bready_s;
  } exp_t;
  exp_t sb[$];
  vec_t tbl[6];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  task automatic cyc();
    @(posedge ACLK);
    #1;
  endtask
  task automatic run_txn(input vec_t v);
    exp_t e;
    int w;
    int si;
    e.resp = v.exp_resp;
    e.bready_s = v.sel;
    sb.push_back(e);
    AWADDR_M = v.addr;
    AWVALID_M = 1'b1;
    AWREADY_S = '1;
    #1;
    chk("aw_valid_s", 32'(AWVALID_S), 32'(v.sel));
    chk("aw_ready_m", 32'(AWREADY_M), 1);
    chk("no_overlap_at_aw", 32'(WVALID_S | BREADY_S), 0);
    cyc();
    AWVALID_M = 1'b0;
    AWREADY_S = '0;
    for (int b = 0; b < v.beats; b++) begin
      WVALID_M = 1'b1;
      WLAST_M = b == v.beats - 1;
      WREADY_S = '1;
      #1;
      chk("w_valid_s", 32'(WVALID_S), 32'(v.sel));
      chk("w_ready_m", 32'(WREADY_M), 1);
      cyc();
    end
    WVALID_M = 1'b0;
    WLAST_M = 1'b0;
    WREADY_S = '0;
    si = int'(v.addr[31:16]);
    BRESP_S = {SC{~v.bresp}};
    if (v.sel != 0) BRESP_S[2*si+:2] = v.bresp;
    BVALID_S = v.sel;
    BREADY_M = 1'b1;
    w = 0;
    #1;
    while (!BVALID_M && w < 8) begin
      cyc();
      w++;
    end
    chk("b_latency", 32'(w), 0);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("b_resp", 32'(BRESP_M), 32'(e.resp));
      chk("b_ready_s", 32'(BREADY_S), 32'(e.bready_s));
    end
    cyc();
    BVALID_S = '0;
    BREADY_M = 1'b0;
    BRESP_S = '0;
    #1;
    chk("busy_after_b", 32'(BUSY), 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    vec_t v;
    tbl[0] = '{32'h0002_0000, 1, 2'b00, 6'b000100, 2'b00};
    tbl[1] = '{32'h0009_0000, 4, 2'b00, 6'b000000, 2'b11};
    tbl[2] = '{32'h0005_1234, 2, 2'b10, 6'b100000, 2'b10};
    tbl[3] = '{32'h0006_0000, 1, 2'b01, 6'b000000, 2'b11};
    tbl[4] = '{32'h0000_ffff, 1, 2'b01, 6'b000001, 2'b01};
    tbl[5] = '{32'hffff_0000, 2, 2'b00, 6'b000000, 2'b11};
    AWADDR_M = 32'h0009_0000;
    AWVALID_M = 1'b1;
    WVALID_M = 1'b1;
    BREADY_M = 1'b1;
    cyc();
    cyc();
    chk("rst_aw_ready_m", 32'(AWREADY_M), 0);
    chk("rst_outputs", 32'({AWVALID_S, WVALID_S, BREADY_S, WREADY_M, BVALID_M, BRESP_M}), 0);
    chk("rst_busy", 32'(BUSY), 0);
    AWVALID_M = 1'b0;
    WVALID_M = 1'b0;
    BREADY_M = 1'b0;
    ARESETn = 1'b1;
    cyc();
    for (int i = 0; i < 6; i++) run_txn(tbl[i]);
    // Backpressure on slave 5: W stalls 3 cycles, then B waits 2 cycles for the master.
    AWADDR_M = 32'h0005_0000;
    AWVALID_M = 1'b1;
    #1;
    chk("bp_aw_ready_low", 32'(AWREADY_M), 0);
    chk("bp_aw_valid_s", 32'(AWVALID_S), 32'h20);
    cyc();
    chk("bp_aw_held", 32'(BUSY), 0);
    AWREADY_S = 6'b100000;
    #1;
    chk("bp_aw_ready_high", 32'(AWREADY_M), 1);
    cyc();
    AWVALID_M = 1'b0;
    AWREADY_S = '0;
    WVALID_M = 1'b1;
    WLAST_M = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_w_stall", 32'(WREADY_M), 0);
      chk("bp_w_valid_s", 32'(WVALID_S), 32'h20);
      cyc();
    end
    WREADY_S = 6'b100000;
    #1;
    chk("bp_w_go", 32'(WREADY_M), 1);
    cyc();
    WVALID_M = 1'b0;
    WLAST_M = 1'b0;
    WREADY_S = '0;
    BVALID_S = 6'b100000;
    BRESP_S = 12'b10_01_01_01_01_01;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("bp_b_valid", 32'(BVALID_M), 1);
      chk("bp_b_resp", 32'(BRESP_M), 2);
      chk("bp_b_ready_s_low", 32'(BREADY_S), 0);
      cyc();
    end
    BREADY_M = 1'b1;
    #1;
    chk("bp_b_ready_s", 32'(BREADY_S), 32'h20);
    cyc();
    BREADY_M = 1'b0;
    BVALID_S = '0;
    BRESP_S = '0;
    #1;
    chk("bp_busy_done", 32'(BUSY), 0);
    // Wrong-state inputs: W/B in IDLE, W alongside the AW handshake, AW again during DATA.
    WVALID_M = 1'b1;
    BREADY_M = 1'b1;
    WREADY_S = '1;
    #1;
    chk("ws_w_ready_idle", 32'(WREADY_M), 0);
    chk("ws_s_idle", 32'({WVALID_S, BREADY_S}), 0);
    cyc();
    chk("ws_busy_idle", 32'(BUSY), 0);
    BREADY_M = 1'b0;
    AWADDR_M = 32'h0001_0000;
    AWVALID_M = 1'b1;
    AWREADY_S = '1;
    #1;
    chk("ws_w_during_aw", 32'(WREADY_M), 0);
    cyc();
    WVALID_M = 1'b0;
    #1;
    chk("ws_aw_ready_data", 32'(AWREADY_M), 0);
    chk("ws_aw_valid_data", 32'(AWVALID_S), 0);
    AWVALID_M = 1'b0;
    AWREADY_S = '0;
    WVALID_M = 1'b1;
    WLAST_M = 1'b1;
    cyc();
    WVALID_M = 1'b0;
    WLAST_M = 1'b0;
    WREADY_S = '0;
    BVALID_S = 6'b000010;
    BREADY_M = 1'b1;
    #1;
    chk("ws_b_valid", 32'(BVALID_M), 1);
    cyc();
    BVALID_S = '0;
    BREADY_M = 1'b0;
    // Reset pulsed in DATA abandons the transaction.
    AWADDR_M = 32'h0003_0000;
    AWVALID_M = 1'b1;
    AWREADY_S = '1;
    cyc();
    AWVALID_M = 1'b0;
    WVALID_M = 1'b1;
    WREADY_S = '1;
    #1;
    chk("rm_in_data", 32'(WREADY_M), 1);
    ARESETn = 1'b0;
    #1;
    chk("rm_w_ready", 32'(WREADY_M), 0);
    chk("rm_w_valid_s", 32'(WVALID_S), 0);
    chk("rm_busy", 32'(BUSY), 0);
    cyc();
    WVALID_M = 1'b0;
    WREADY_S = '0;
    AWREADY_S = '0;
    ARESETn = 1'b1;
    cyc();
    chk("rm_idle_after", 32'(BUSY), 0);
    v = '{32'h0000_0000, 1, 2'b00, 6'b000001, 2'b00};
    run_txn(v);
    // Back-to-back: slave 3 AW lands in the cycle right after slave 1's B handshake.
    v = '{32'h0001_0000, 1, 2'b00, 6'b000010, 2'b00};
    run_txn(v);
    v = '{32'h0003_0000, 2, 2'b10, 6'b001000, 2'b10};
    run_txn(v);
    chk("sb_drained", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/axi_wr_route.md
# axi_wr_route

Write-channel router between the single arbitrated master port and the SlaveCount slave ports of the AXI interconnect. It decodes AWADDR to a one-hot slave select and forwards AWVALID/WVALID/BREADY to that slave. It returns the selected slave's AWREADY/WREADY/BVALID/BRESP to the master and holds the route until the B handshake completes. Unmapped addresses are absorbed by an internal default slave that returns DECERR.

## Interface

- SlaveCount, 6, number of slave ports
- AddrWidth, 32, AWADDR width; slave index field is AWADDR[AddrWidth-1:16]

Ports:

- ACLK  in  1  clock
- ARESETn  in  1  reset
- AWADDR_M  in  AddrWidth  master write address
- AWVALID_M  in  1  master address valid
- AWREADY_M  out  1  address ready to master
- AWVALID_S  out  SlaveCount  one-hot address valid to slaves
- AWREADY_S  in  SlaveCount  slave address ready
- WVALID_M  in  1  master write data valid
- WLAST_M  in  1  last beat of burst
- WREADY_M  out  1  data ready to master
- WVALID_S  out  SlaveCount  one-hot data valid to slaves
- WREADY_S  in  SlaveCount  slave data ready
- BVALID_S  in  SlaveCount  slave response valid
- BRESP_S  in  2*SlaveCount  slave responses, slave i at [2i+1:2i]
- BVALID_M  out  1  response valid to master
- BRESP_M  out  2  response to master
- BREADY_M  in  1  master response ready
- BREADY_S  out  SlaveCount  one-hot response ready to slaves
- BUSY  out  1  high whenever state is not IDLE

Clocking and reset: one clock, ACLK. ARESETn is asynchronous and active-low.

## Operation

- Decode: idx = AWADDR_M[AddrWidth-1:16]. If idx < SlaveCount, dec = one-hot(idx). Otherwise dec = 0 and the transaction targets the default slave.
- State machine: IDLE → DATA → RESP → IDLE.
- Registers: sel (SlaveCount bits) and derr (1 bit).
- IDLE:
  - AWVALID_S = dec & {AWVALID_M}.
  - AWREADY_M = AWREADY_S[idx] for a mapped address; 1 for an unmapped address.
  - On AWVALID_M & AWREADY_M: sel ← dec, derr ← (dec == 0), go to DATA.
  - All W and B outputs are 0.
- DATA:
  - WVALID_S = sel & {WVALID_M}.
  - WREADY_M = OR(sel & WREADY_S) when derr = 0; 1 when derr = 1.
  - On WVALID_M & WREADY_M & WLAST_M: go to RESP.
  - Non-last beats stay in DATA. AW outputs are 0.
- RESP:
  - When derr = 0: BVALID_M = OR(sel & BVALID_S), BRESP_M = BRESP_S of the selected slave, BREADY_S = sel & {BREADY_M}.
  - When derr = 1: BVALID_M = 1, BRESP_M = 2'b11 (DECERR), BREADY_S = 0.
  - On BVALID_M & BREADY_M: go to IDLE and clear sel and derr.
- At most one bit of any *_S output is ever high.
- Payload buses (AWADDR, WDATA, WSTRB, BID) are broadcast outside this block and are not routed here.

## Timing

- Reset values: state IDLE, sel 0, derr 0, BUSY 0.
- While ARESETn is low, all outputs are forced to 0, including the combinational outputs.
- Reset asserted mid-transaction abandons the transaction immediately. No response is generated.
- AW path: combinational in IDLE. AWREADY_M follows the same cycle as AWREADY_S.
- A W beat is never accepted in the same cycle as the AW handshake. The earliest W handshake is the cycle after the AW handshake.
- W and B paths: combinational from the registered sel.
- DECERR timing:
  - Each W beat completes in the cycle WVALID_M is high.
  - BVALID_M rises the cycle after the WLAST handshake.
  - BVALID_M holds until BREADY_M is seen.
- Back-to-back transactions: after the B handshake, the next AW can complete in the following cycle (IDLE).
- WVALID_M or BREADY_M asserted in the wrong state is ignored; its ready/valid response stays 0.
- Input stability: AWADDR_M must be stable while AWVALID_M is high and unacknowledged. This is an AXI rule; the router does not re-check it.
- Minimum mapped single-beat transaction: AW at cycle 0, W at cycle 1, B at cycle 2 or later.

## Structure

- Shared axi_pkg:
  - RESP_OKAY = 2'b00, RESP_DECERR = 2'b11.
  - Slave index field LSB (16).
  - Route state enum {IDLE, DATA, RESP}.
- Sub-module axi_wr_decode: combinational AWADDR → one-hot dec plus an unmapped flag. The read router reuses it.
- The ready/valid return paths are AND-OR reductions of sel against the slave vectors.

## Test plan

- Mapped single beat:
  - Stimulus: AWADDR_M = 0x0002_0000, slave 2 AWREADY = 1.
  - Response: AWVALID_S = 6'b000100, WVALID_S = 6'b000100 next cycle.
  - Slave 2 BRESP = 2'b00 appears on BRESP_M; BUSY then drops.
- Unmapped 4-beat burst:
  - Stimulus: AWADDR_M = 0x0009_0000.
  - Response: AWREADY_M = 1 immediately, all *_S outputs stay 0, 4 WREADY_M cycles.
  - BVALID_M = 1 with BRESP_M = 2'b11 one cycle after WLAST.
- Backpressure:
  - Stimulus: slave 5 holds WREADY_S low for 3 cycles, then BVALID_S = 1 while BREADY_M is low for 2 cycles.
  - Response: WREADY_M mirrors WREADY_S; BVALID_M and BRESP_M stay stable until the handshake.
- Wrong-state inputs:
  - Stimulus: WVALID_M asserted in IDLE, and AWVALID_M asserted in DATA.
  - Response: no WREADY_M and no second AWREADY_M.
- Reset mid-transaction:
  - Stimulus: ARESETn pulsed low during DATA.
  - Response: all outputs 0 immediately, BUSY = 0, next AW to slave 0 routes correctly.
- Back-to-back:
  - Stimulus: slave 1 transaction followed immediately by a slave 3 transaction.
  - Response: AWVALID_S = 6'b001000 in the cycle after the first B handshake, no overlap on *_S.
